coeff_bank_writer: RTL
======================

COEFF_BANK_WRITER -- requirements
Module: coeff_bank_writer

Interface
REQ-001 Parameter COEFF_CNT, default 25, number of valid coefficient addresses (1..64).
REQ-002 Parameter DATA_W, default 32, coefficient word width.
REQ-003 Port clk, in, 1: single clock; all logic on rising edge (pixel clock domain).
REQ-004 Port rst, in, 1: reset, synchronous, active-high.
REQ-005 Port wr_valid_i, in, 1: write request valid.
REQ-006 Port wr_ready_o, out, 1: block accepts write; transfer occurs when wr_valid_i and wr_ready_o are both 1 on an edge.
REQ-007 Port wr_addr_i, in, 6: coefficient address of write.
REQ-008 Port wr_data_i, in, DATA_W: coefficient value of write.
REQ-009 Port commit_i, in, 1: request to publish the shadow bank at next frame boundary.
REQ-010 Port vs_i, in, 1: vertical sync from video pipeline, active-high.
REQ-011 Port rd_addr_i, in, 6: read address from filter.
REQ-012 Port rd_data_o, out, DATA_W: active-bank coefficient, registered.
REQ-013 Port pending_o, out, 1: commit accepted, swap not yet done.
REQ-014 Port active_bank_o, out, 1: index of bank currently read by filter.
REQ-015 Port swap_cnt_o, out, 8: number of completed swaps.
REQ-016 Port err_o, out, 1: sticky out-of-range write flag.

Function
REQ-017 Two banks of 64 x DATA_W storage; active bank = active_bank_o, shadow bank = its complement.
REQ-018 rd_data_o SHALL equal active bank word at rd_addr_i sampled on previous edge (1-cycle latency, BRAM-compatible).
REQ-019 States: LOAD, PENDING, COPY; wr_ready_o = 1 only in LOAD.
REQ-020 LOAD: each accepted write with wr_addr_i < COEFF_CNT stores wr_data_i into shadow bank at wr_addr_i.
REQ-021 Accepted write with wr_addr_i >= COEFF_CNT SHALL complete handshake, not modify storage, and set err_o; err_o clears only on rst or on entry to PENDING.
REQ-022 LOAD -> PENDING when commit_i = 1; a write accepted in the same cycle SHALL land in shadow before the swap.
REQ-023 vs rising edge = vs_i 1 this cycle and 0 the previous cycle; history register reset to 0.
REQ-024 PENDING -> COPY on vs rising edge: active_bank_o toggles, swap_cnt_o increments (255 wraps to 0), pending_o falls, all on that edge.
REQ-025 Commit and vs rising edge in the same LOAD cycle: enter PENDING only; swap waits for next vs rising edge.
REQ-026 Reads sampled on edges after the swap edge SHALL return new-bank data; no read returns mixed-bank data.
REQ-027 COPY: copy active bank addresses 0..COEFF_CNT-1 into shadow bank so partial reloads keep unchanged coefficients; COPY lasts exactly COEFF_CNT+1 cycles, then LOAD.
REQ-028 vs_i edges and commit_i in PENDING or COPY SHALL be ignored (no second swap, no queued commit).
REQ-029 Filter read port SHALL be independent of copy traffic; rd_data_o latency unchanged during COPY.
REQ-030 pending_o = 1 exactly while state is PENDING.

Reset
REQ-031 While rst = 1: state LOAD, wr_ready_o 0, pending_o 0, active_bank_o 0, swap_cnt_o 0, err_o 0, rd_data_o 0, vs history 0.
REQ-032 First edge after rst falls: wr_ready_o 1.
REQ-033 rst during PENDING or COPY SHALL abort the operation with no swap and no counter change beyond reset values.
REQ-034 Storage contents are not cleared by rst; they are undefined until written.

Verification
REQ-035 Load addr 0..24 with 0x100+addr, commit, vs pulse -> active_bank_o 1, swap_cnt_o 1, rd_addr 7 returns 0x107 one cycle later; wr_ready_o returns to 1 exactly 26 cycles after swap edge.
REQ-036 After REQ-035, write only addr 3 = 0xDEAD, commit, vs pulse -> addr 3 reads 0xDEAD, addr 4 reads 0x104 (copy preserved).
REQ-037 Write addr 40 = 0x55 -> handshake completes, err_o 1, storage unchanged; next commit clears err_o.
REQ-038 commit_i and vs rising edge in same cycle -> no swap that edge, pending_o 1; swap on next vs rising edge.
REQ-039 Hold vs_i high 10 cycles while PENDING -> exactly one swap; extra commit and vs pulses during COPY -> swap_cnt_o increments once.
REQ-040 Assert rst mid-COPY -> active_bank_o 0, swap_cnt_o 0, pending_o 0, wr_ready_o 1 one cycle after rst falls; 256 swaps -> swap_cnt_o wraps to 0.

Source files
------------

// File: rtl/coeff_bank_writer.sv
// Double-buffered coefficient bank: writes land in the shadow bank, a commit
// publishes it on the next vsync rising edge, then the new bank is mirrored back.
module coeff_bank_writer #(
  parameter int COEFF_CNT = 25,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [5:0]        wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              commit_i,
  input  logic              vs_i,
  input  logic [5:0]        rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              pending_o,
  output logic              active_bank_o,
  output logic [7:0]        swap_cnt_o,
  output logic              err_o
);

  typedef enum logic [1:0] {LOAD, PENDING, COPY} state_t;

  state_t            state;
  logic              vs_q;
  logic              vs_rise;
  logic              wr_fire;
  logic              wr_in_range;
  logic [6:0]        cp_cnt;

  // Two banks share one array; the bank index is the address MSB.
  logic [DATA_W-1:0] mem [128];
  logic              mem_we;
  logic [6:0]        mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              cp_vld_p1;
  logic [5:0]        cp_addr_p1;
  logic [DATA_W-1:0] cp_data_p1;

  assign vs_rise     = vs_i & ~vs_q;
  assign wr_fire     = wr_valid_i & wr_ready_o;
  assign wr_in_range = ({1'b0, wr_addr_i} < 7'(COEFF_CNT));

  // Copy traffic and host writes never overlap: writes are only accepted in LOAD.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (cp_vld_p1) begin
      mem_we    = 1'b1;
      mem_waddr = {~active_bank_o, cp_addr_p1};
      mem_wdata = cp_data_p1;
    end else if (wr_fire && wr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = {~active_bank_o, wr_addr_i};
      mem_wdata = wr_data_i;
    end
  end

  // Stage p0 -> p1: copy read of the active bank, written to shadow next cycle
  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      mem[mem_waddr] <= mem_wdata;
    cp_data_p1 <= mem[{active_bank_o, cp_cnt[5:0]}];
    cp_addr_p1 <= cp_cnt[5:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      wr_ready_o    <= 1'b0;
      pending_o     <= 1'b0;
      active_bank_o <= 1'b0;
      swap_cnt_o    <= 8'd0;
      err_o         <= 1'b0;
      vs_q          <= 1'b0;
      cp_cnt        <= 7'd0;
      cp_vld_p1     <= 1'b0;
      rd_data_o     <= '0;
    end else begin
      vs_q      <= vs_i;
      rd_data_o <= mem[{active_bank_o, rd_addr_i}];
      cp_vld_p1 <= 1'b0;
      case (state)
        LOAD: begin
          wr_ready_o <= 1'b1;
          if (wr_fire && !wr_in_range)
            err_o <= 1'b1;
          if (commit_i) begin
            state      <= PENDING;
            wr_ready_o <= 1'b0;
            pending_o  <= 1'b1;
            err_o      <= 1'b0;
          end
        end
        PENDING: begin
          if (vs_rise) begin
            state         <= COPY;
            active_bank_o <= ~active_bank_o;
            swap_cnt_o    <= swap_cnt_o + 8'd1;
            pending_o     <= 1'b0;
            cp_cnt        <= 7'd0;
          end
        end
        COPY: begin
          cp_vld_p1 <= (cp_cnt < 7'(COEFF_CNT));
          if (cp_cnt == 7'(COEFF_CNT)) begin
            state      <= LOAD;
            wr_ready_o <= 1'b1;
          end else begin
            cp_cnt <= cp_cnt + 7'd1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
